// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Pipeline stage register carrying a PC and an instruction word. It uses a
//   valid/ready handshake and a two-entry skid buffer (main = head, skid =
//   overflow), so it sustains one entry per cycle under back-pressure.
//   A flush drops every held and incoming entry and shows a NOP bubble
//   downstream. A saturating counter records the cycles spent in flush.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset (overrides flush)
//   pipeline_flush discard held and incoming entries this cycle
//   in_valid/in_ready/in_pc/in_instr       upstream handshake and payload
//   out_valid/out_ready/out_pc/out_instr   downstream handshake and payload
//   out_bubble     !out_valid
//   occupancy      number of held entries (0..2)
//   flush_count    saturating count of flush cycles
module pipe_stage_skid #(
  parameter int unsigned         PC_W        = 32,
  parameter int unsigned         INSTR_W     = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR   = 32'h00000013,
  parameter logic [PC_W-1:0]     RESET_PC    = 32'h00000000,
  parameter int unsigned         FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipeline_flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [INSTR_W-1:0]     in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [INSTR_W-1:0]     out_instr,
  output logic                   out_bubble,
  output logic [1:0]             occupancy,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      main_pc_q, main_pc_d;
  logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
  logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic pop;

  // Entry valid bits are implied by the state: main holds an entry in BUSY
  // and FULL, skid only in FULL.
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  // in_ready depends only on registered state and the flush gate, never on
  // out_ready, so no combinational ready path crosses the stage.
  assign in_ready  = !skid_valid && !pipeline_flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = main_valid;
  assign pop       = out_valid && out_ready;

  assign out_pc     = main_valid ? main_pc_q    : RESET_PC;
  assign out_instr  = main_valid ? main_instr_q : NOP_INSTR;
  assign out_bubble = !main_valid;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (pipeline_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
            state_d      = BUSY;
          end
        end
        BUSY: begin
          if (accept && pop) begin
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
          end else if (accept) begin
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
            state_d      = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            state_d      = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (pipeline_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_pc_q    <= '0;
      main_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid. A second instance with a 2-bit flush
// counter shares all inputs and is used to observe counter saturation.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipeline_flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_bubble;
  logic [1:0]  occupancy;
  logic [15:0] flush_count;

  logic        s_in_ready, s_out_valid, s_out_bubble;
  logic [31:0] s_out_pc, s_out_instr;
  logic [1:0]  s_occupancy;
  logic [1:0]  s_flush_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .pipeline_flush(pipeline_flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_bubble(out_bubble), .occupancy(occupancy),
    .flush_count(flush_count)
  );

  pipe_stage_skid #(.FLUSH_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pipeline_flush(pipeline_flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc),
    .out_instr(s_out_instr), .out_bubble(s_out_bubble), .occupancy(s_occupancy),
    .flush_count(s_flush_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    in_valid       = v;
    in_pc          = pc;
    in_instr       = ins;
    out_ready      = ordy;
    pipeline_flush = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_bubble !== 1'b1) begin fails++; $display("FAIL reset_bubble got %0b want 1", out_bubble); end
    checks++; if (out_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", out_pc); end
    checks++; if (out_instr !== 32'h00000013) begin fails++; $display("FAIL reset_instr got %h want 00000013", out_instr); end
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if (flush_count !== 16'd0) begin fails++; $display("FAIL reset_fcnt got %0d want 0", flush_count); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    pcs = '{32'h0, 32'h4, 32'h8};
    ins = '{32'h00500093, 32'h00A00113, 32'h002081B3};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], ins[i], 1'b1, 1'b0);
      tick();
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got %0b want 1", i, out_valid); end
      checks++; if (out_pc !== pcs[i]) begin fails++; $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, pcs[i]); end
      checks++; if (out_instr !== ins[i]) begin fails++; $display("FAIL stream_instr[%0d] got %h want %h", i, out_instr, ins[i]); end
      checks++; if (occupancy !== 2'd1) begin fails++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h4, 32'h00A00113, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h8, 32'h002081B3, 1'b0, 1'b0);
    tick();
    checks++; if (occupancy !== 2'd2) begin fails++; $display("FAIL bp_occ got %0d want 2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
    checks++; if (out_pc !== 32'h4) begin fails++; $display("FAIL bp_head got %h want 4", out_pc); end
    // Held in FULL: a further offer must not be taken.
    drive(1'b1, 32'hDEAD, 32'h0, 1'b0, 1'b0);
    tick();
    checks++; if (out_pc !== 32'h4) begin fails++; $display("FAIL bp_hold got %h want 4", out_pc); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checks++; if (out_pc !== 32'h8) begin fails++; $display("FAIL bp_second_pc got %h want 8", out_pc); end
    checks++; if (out_instr !== 32'h002081B3) begin fails++; $display("FAIL bp_second_instr got %h want 002081b3", out_instr); end
    checks++; if (occupancy !== 2'd1) begin fails++; $display("FAIL bp_recover_occ got %0d want 1", occupancy); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_recover_ready got %0b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h20, 32'h11111111, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h24, 32'h22222222, 1'b0, 1'b0);
    tick();
    checks++; if (occupancy !== 2'd2) begin fails++; $display("FAIL flush_pre_occ got %0d want 2", occupancy); end
    drive(1'b1, 32'hC, 32'h33333333, 1'b0, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    checks++; if (out_instr !== 32'h00000013) begin fails++; $display("FAIL flush_instr got %h want 00000013", out_instr); end
    checks++; if (out_pc !== 32'h0) begin fails++; $display("FAIL flush_pc got %h want 0", out_pc); end
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL flush_occ got %0d want 0", occupancy); end
    checks++; if (flush_count !== 16'd1) begin fails++; $display("FAIL flush_cnt got %0d want 1", flush_count); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready_after got %0b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost[%0d] got valid=%0b pc=%h want 0", i, out_valid, out_pc); end
    end
  endtask

  task automatic test_accept_pop();
    drive(1'b1, 32'h10, 32'h44444444, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h14, 32'h55555555, 1'b1, 1'b0);
    tick();
    checks++; if (out_pc !== 32'h14) begin fails++; $display("FAIL ap_pc got %h want 14", out_pc); end
    checks++; if (out_instr !== 32'h55555555) begin fails++; $display("FAIL ap_instr got %h want 55555555", out_instr); end
    checks++; if (occupancy !== 2'd1) begin fails++; $display("FAIL ap_occ got %0d want 1", occupancy); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL ap_drain got %0d want 0", occupancy); end
  endtask

  task automatic test_flush_sat();
    logic [1:0] exp_sat [5];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (s_flush_count !== exp_sat[i]) begin fails++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, s_flush_count, exp_sat[i]); end
      checks++; if (flush_count !== 16'(i + 1)) begin fails++; $display("FAIL wide_cnt[%0d] got %0d want %0d", i, flush_count, i + 1); end
    end
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    checks++; if (s_flush_count !== 2'd0) begin fails++; $display("FAIL sat_reset got %0d want 0", s_flush_count); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h30, 32'h66666666, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h34, 32'h77777777, 1'b0, 1'b0);
    tick();
    checks++; if (occupancy !== 2'd2) begin fails++; $display("FAIL rm_pre_occ got %0d want 2", occupancy); end
    rst = 1'b1;
    drive(1'b1, 32'h38, 32'h88888888, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_valid got %0b want 0", out_valid); end
    checks++; if (out_bubble !== 1'b1) begin fails++; $display("FAIL rm_bubble got %0b want 1", out_bubble); end
    checks++; if (out_pc !== 32'h0) begin fails++; $display("FAIL rm_pc got %h want 0", out_pc); end
    checks++; if (out_instr !== 32'h00000013) begin fails++; $display("FAIL rm_instr got %h want 00000013", out_instr); end
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL rm_occ got %0d want 0", occupancy); end
    checks++; if (flush_count !== 16'd0) begin fails++; $display("FAIL rm_fcnt got %0d want 0", flush_count); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rm_in_ready got %0b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_accept_pop();
    test_flush_sat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
